shift_result_fifo: RTL and testbench

- Downstream capture stage for the parameterized barrel shifter.
- Accepts the shifter's combinational left and right results plus the shift amount and a direction select.
- Stores the selected result in a small FIFO and presents it to the next consumer over a valid/ready handshake.
- Decouples the combinational shifter from a registered, back-pressured consumer, and counts completed operations.

---
 rtl/shift_pkg.sv | 30 +++
 rtl/sync_fifo_core.sv | 60 ++++++
 rtl/shift_result_fifo.sv | 78 +++++++
 tb/tb_shift_result_fifo.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// shift_pkg: shared direction type, default entry shape and width helpers for the shift result FIFO.
package shift_pkg;

   typedef enum logic {
      DIR_LEFT  = 1'b0,
      DIR_RIGHT = 1'b1
   } shift_dir_e;

   localparam int N_DEF = 3;

   // Reference entry shape at the default width; modules rebuild it from their own N.
   typedef struct packed {
      logic [2**N_DEF-1:0] data;
      logic [N_DEF-1:0]    amt;
      shift_dir_e          dir;
   } shift_entry_t;

   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   function automatic int entry_w(input int n);
      return (2**n) + n + 1;
   endfunction

endpackage

// File: rtl/sync_fifo_core.sv
// sync_fifo_core: generic first-word-fall-through FIFO storage with pointers and occupancy count.
module sync_fifo_core
   import shift_pkg::*;
#(
   parameter int WIDTH = 12,
   parameter int DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      i_push,
   input  logic                      i_pop,
   input  logic [WIDTH-1:0]          i_data,
   output logic [WIDTH-1:0]          o_data,
   output logic [cnt_w(DEPTH)-1:0]   o_count,
   output logic                      o_full,
   output logic                      o_empty
);

   localparam int PW = ptr_w(DEPTH);
   localparam int CW = cnt_w(DEPTH);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   generate
      if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
         $error("sync_fifo_core: DEPTH must be a power of 2 and at least 2");
      end
   endgenerate

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full  = r_count == FULL;
   assign o_empty = r_count == '0;
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;
   assign o_count = r_count;
   assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of 2; full/empty come from the count alone.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_data;
   end

endmodule

// File: rtl/shift_result_fifo.sv
// shift_result_fifo: captures the selected barrel-shifter result into a FIFO and hands it
// to a back-pressured consumer, counting completed pops.
module shift_result_fifo
   import shift_pkg::*;
#(
   parameter int N     = 3,
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic                      in_dir,
   input  logic [N-1:0]              in_amt,
   input  logic [2**N-1:0]           left_shifted,
   input  logic [2**N-1:0]           right_shifted,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [2**N-1:0]           out_data,
   output logic [N-1:0]              out_amt,
   output logic                      out_dir,
   output logic                      out_zero,
   output logic [cnt_w(DEPTH)-1:0]   count,
   output logic [CNT_W-1:0]          op_count
);

   localparam int W = 2**N;

   typedef struct packed {
      logic [W-1:0] data;
      logic [N-1:0] amt;
      shift_dir_e   dir;
   } entry_t;

   entry_t           w_wr_entry;
   entry_t           w_rd_entry;
   logic             w_full;
   logic             w_empty;
   logic             w_pop;
   logic [CNT_W-1:0] r_op_count;

   always_comb begin
      w_wr_entry.dir  = shift_dir_e'(in_dir);
      w_wr_entry.amt  = in_amt;
      w_wr_entry.data = (w_wr_entry.dir == DIR_RIGHT) ? right_shifted : left_shifted;
   end

   sync_fifo_core #(
      .WIDTH($bits(entry_t)),
      .DEPTH(DEPTH)
   ) u_core (
      .clk     (clk),
      .reset   (reset),
      .i_push  (in_valid),
      .i_pop   (out_ready),
      .i_data  (w_wr_entry),
      .o_data  (w_rd_entry),
      .o_count (count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign in_ready  = !w_full;
   assign out_valid = !w_empty;
   assign w_pop     = out_valid && out_ready;
   assign out_data  = w_rd_entry.data;
   assign out_amt   = w_rd_entry.amt;
   assign out_dir   = w_rd_entry.dir;
   assign out_zero  = out_valid && (w_rd_entry.data == '0);
   assign op_count  = r_op_count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_op_count <= '0;
      else if (w_pop) r_op_count <= r_op_count + 1'b1;
   end

endmodule

// File: tb/tb_shift_result_fifo.sv
// tb_shift_result_fifo: scoreboard bench for shift_result_fifo (N=3, DEPTH=4, CNT_W=4).
module tb_shift_result_fifo;

   localparam int N     = 3;
   localparam int DEPTH = 4;
   localparam int CNT_W = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid;
   logic       in_ready;
   logic       in_dir;
   logic [2:0] in_amt;
   logic [7:0] left_shifted;
   logic [7:0] right_shifted;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic [2:0] out_amt;
   logic       out_dir;
   logic       out_zero;
   logic [2:0] count;
   logic [3:0] op_count;

   int errors = 0;
   int checks = 0;
   logic [11:0] sb[$];
   logic [3:0]  exp_ops = '0;

   shift_result_fifo #(.N(N), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk           (clk),
      .reset         (reset),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_dir        (in_dir),
      .in_amt        (in_amt),
      .left_shifted  (left_shifted),
      .right_shifted (right_shifted),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_data      (out_data),
      .out_amt       (out_amt),
      .out_dir       (out_dir),
      .out_zero      (out_zero),
      .count         (count),
      .op_count      (op_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock: drive inputs, check DUT against the model mid-cycle, then let the model follow the edge.
   task automatic step(input logic v, input logic dir, input logic [2:0] amt,
                       input logic [7:0] l, input logic [7:0] r, input logic rdy);
      logic push, pop;
      logic [11:0] head;
      in_valid = v; in_dir = dir; in_amt = amt;
      left_shifted = l; right_shifted = r; out_ready = rdy;
      @(negedge clk);
      chk("in_ready", in_ready, sb.size() != DEPTH);
      chk("out_valid", out_valid, sb.size() != 0);
      chk("count", count, sb.size());
      push = v && sb.size() != DEPTH;
      pop  = rdy && sb.size() != 0;
      if (sb.size() != 0) begin
         head = sb[0];
         chk("out_data", out_data, head[11:4]);
         chk("out_amt", out_amt, head[3:1]);
         chk("out_dir", out_dir, head[0]);
         chk("out_zero", out_zero, head[11:4] == 8'h00);
      end else begin
         chk("empty_data", {out_data, out_amt, out_dir}, 0);
      end
      @(posedge clk);
      #1;
      if (pop) begin
         void'(sb.pop_front());
         exp_ops = exp_ops + 1'b1;
      end
      if (push) sb.push_back({dir ? r : l, amt, dir});
      chk("op_count", op_count, exp_ops);
   endtask

   initial begin
      reset = 1'b1; in_valid = 0; in_dir = 0; in_amt = 0;
      left_shifted = 0; right_shifted = 0; out_ready = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_count", count, 0);
      chk("rst_op_count", op_count, 0);
      reset = 1'b0;

      // single push, then pop
      step(1, 0, 3'd3, 8'hA0, 8'h05, 0);
      chk("single_count", count, 1);
      chk("single_data", out_data, 8'hA0);
      step(0, 0, 0, 0, 0, 1);

      // fill with back-pressure, fifth push ignored, then drain
      for (int i = 1; i <= 4; i++) step(1, 1, 3'(i), 8'hFF, 8'(i), 0);
      chk("full_count", count, 4);
      chk("full_in_ready", in_ready, 0);
      step(1, 1, 3'd5, 8'hFF, 8'h05, 0);
      chk("fifth_ignored", count, 4);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1);
      chk("drain_ops", op_count, 5);
      chk("drain_empty", out_valid, 0);

      // zero flag
      step(1, 1, 3'd2, 8'h11, 8'h00, 0);
      chk("zero_head", out_zero, 1);
      step(1, 1, 3'd7, 8'h22, 8'h80, 1);
      chk("nonzero_head", out_zero, 0);
      step(0, 0, 0, 0, 0, 1);

      // continuous push/pop at count=2 across pointer wrap
      step(1, 0, 3'd1, 8'h31, 8'h00, 0);
      step(1, 1, 3'd2, 8'h00, 8'h32, 0);
      for (int i = 0; i < 12; i++) begin
         step(1, i[0], 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 1);
         chk("steady_count", count, 2);
      end
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 1);

      // reset mid-operation
      for (int i = 0; i < 3; i++) step(1, 0, 3'(i), 8'h40 + 8'(i), 8'h00, 0);
      chk("pre_rst_count", count, 3);
      reset = 1'b1;
      #1;
      chk("async_out_valid", out_valid, 0);
      chk("async_count", count, 0);
      sb.delete();
      exp_ops = '0;
      #1;
      reset = 1'b0;
      #1;
      chk("post_rst_in_ready", in_ready, 1);
      step(1, 1, 3'd6, 8'h00, 8'h5A, 0);
      chk("post_rst_first", out_data, 8'h5A);

      // op counter wrap: 17 pops with a 4-bit counter
      step(1, 0, 3'd1, 8'h61, 8'h00, 1);
      for (int i = 0; i < 15; i++) step(1, 1, 3'(i), 8'h00, 8'(i), 1);
      step(0, 0, 0, 0, 0, 1);
      chk("op_wrap", op_count, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #50000;
      errors++;
      $display("FAIL timeout: got no finish expected finish");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "timeout");
   end

endmodule
